and4_sweep_checker: RTL and testbench

Built-in self-test exerciser for an N-input AND-reduction block (default 4 inputs, matching `nested_and4_example`). On a `start` pulse it drives every input pattern in ascending order onto the DUT inputs and holds each pattern for a programmable dwell. It samples the DUT's single `result` output, compares it against the expected AND of the pattern, and reports pass/fail, a mismatch count and the first failing pattern. It sits beside the AND block, replacing the exhaustive for-loop stimulus with synthesizable hardware.

---
 rtl/and4_sweep_checker.sv | 119 +++++++++++
 tb/tb_and4_sweep_checker.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/and4_sweep_checker.sv
// Exhaustive sweep checker for an N-input AND-reduction block. Steps every input pattern in
// ascending order, holds each for DWELL cycles, compares the DUT result on the last dwell cycle
// against &drive and reports pass/fail, a saturating mismatch count and the first failing pattern.
module and4_sweep_checker #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned DWELL = 2,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             result_i,
  output logic [N_IN-1:0]  drive_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_count_o,
  output logic [N_IN-1:0]  first_fail_o,
  output logic             first_fail_valid_o
);

  localparam int unsigned   CntW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e           state_q, state_d;
  logic [N_IN-1:0]  drive_q, drive_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic [N_IN-1:0]  ff_q, ff_d;
  logic             ffv_q, ffv_d;

  logic mismatch;
  assign mismatch = (result_i != (&drive_q));

  // Next-state logic: sequences the sweep and accumulates compare results.
  always_comb begin
    state_d = state_q;
    drive_d = drive_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          drive_d = '0;
          cnt_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          ff_d    = '0;
          ffv_d   = 1'b0;
        end
      end
      StRun: begin
        if (cnt_q == CntLast) begin
          if (mismatch) begin
            if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
            if (!ffv_q) begin
              ff_d  = drive_q;
              ffv_d = 1'b1;
            end
          end
          cnt_d = '0;
          if (&drive_q) begin
            // Last pattern: its own compare is already folded into err_d.
            state_d = StFinish;
            drive_d = '0;
            pass_d  = (err_d == '0);
          end else begin
            drive_d = drive_q + N_IN'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset drops any sweep in progress.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      drive_q <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drive_q <= drive_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
    end
  end

  assign drive_o            = drive_q;
  assign busy_o             = (state_q == StRun);
  assign done_o             = (state_q == StFinish);
  assign pass_o             = pass_q;
  assign err_count_o        = err_q;
  assign first_fail_o       = ff_q;
  assign first_fail_valid_o = ffv_q;

endmodule

// File: tb/tb_and4_sweep_checker.sv
// Bench for and4_sweep_checker: a default instance checks a modelled AND block with a random
// per-pattern fault mask; a second instance with ERR_W=2 sees a result stuck at 1.
`timescale 1ns/1ps
module tb_and4_sweep_checker;

  localparam int unsigned NPat   = 16;
  localparam int unsigned Dwell  = 2;
  localparam int unsigned RunCyc = NPat * Dwell;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] fault_mask = '0;

  logic [3:0] drive_a, ff_a, drive_b, ff_b;
  logic       busy_a, done_a, pass_a, ffv_a, busy_b, done_b, pass_b, ffv_b;
  logic [7:0] err_a;
  logic [1:0] err_b;
  logic       result_a;

  // Good AND behaviour with pattern p inverted wherever fault_mask[p] is set.
  assign result_a = (&drive_a) ^ fault_mask[drive_a];

  always #5 clk = ~clk;

  and4_sweep_checker u_dut_a (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .start_i            (start),
    .result_i           (result_a),
    .drive_o            (drive_a),
    .busy_o             (busy_a),
    .done_o             (done_a),
    .pass_o             (pass_a),
    .err_count_o        (err_a),
    .first_fail_o       (ff_a),
    .first_fail_valid_o (ffv_a)
  );

  and4_sweep_checker #(
    .N_IN  (4),
    .DWELL (2),
    .ERR_W (2)
  ) u_dut_b (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .start_i            (start),
    .result_i           (1'b1),
    .drive_o            (drive_b),
    .busy_o             (busy_b),
    .done_o             (done_b),
    .pass_o             (pass_b),
    .err_count_o        (err_b),
    .first_fail_o       (ff_b),
    .first_fail_valid_o (ffv_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: mismatches among the first npats patterns, saturated at sat.
  function automatic int unsigned model_err(input logic [15:0] m, input int unsigned npats,
                                            input int unsigned sat);
    int unsigned cnt = 0;
    for (int i = 0; i < 16; i++) if (i < npats && m[i]) cnt++;
    return (cnt > sat) ? sat : cnt;
  endfunction

  function automatic int unsigned model_ff(input logic [15:0] m, input int unsigned npats);
    for (int i = 0; i < 16; i++) if (i < npats && m[i]) return i;
    return 0;
  endfunction

  function automatic int unsigned model_ffv(input logic [15:0] m, input int unsigned npats);
    for (int i = 0; i < 16; i++) if (i < npats && m[i]) return 1;
    return 0;
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_drive"}, 32'(drive_a), 0);
    check_eq({tag, "_busy"},  32'(busy_a), 0);
    check_eq({tag, "_done"},  32'(done_a), 0);
    check_eq({tag, "_pass"},  32'(pass_a), 0);
    check_eq({tag, "_err"},   32'(err_a), 0);
    check_eq({tag, "_ff"},    32'(ff_a), 0);
    check_eq({tag, "_ffv"},   32'(ffv_a), 0);
    check_eq({tag, "_b_err"}, 32'(err_b), 0);
    check_eq({tag, "_b_ffv"}, 32'(ffv_b), 0);
  endtask

  // One full sweep. Sample k is taken #1 after the k-th edge counting the accept edge as 1.
  task automatic sweep(input logic [15:0] mask, input bit hold, input int unsigned poke_k);
    int unsigned c, np;
    fault_mask = mask;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int unsigned k = 1; k <= RunCyc; k++) begin
      c  = k - 1;
      np = c / Dwell;
      check_eq("run_drive", 32'(drive_a), c / Dwell);
      check_eq("run_busy",  32'(busy_a), 1);
      check_eq("run_done",  32'(done_a), 0);
      check_eq("run_pass",  32'(pass_a), 0);
      check_eq("run_err",   32'(err_a), model_err(mask, np, 255));
      check_eq("run_ff",    32'(ff_a), model_ff(mask, np));
      check_eq("run_ffv",   32'(ffv_a), model_ffv(mask, np));
      check_eq("run_b_err", 32'(err_b), model_err(16'h7FFF, np, 3));
      if (!hold && poke_k != 0) begin
        if (k == poke_k) start = 1'b1;
        else if (k == poke_k + 1) start = 1'b0;
      end
      @(posedge clk); #1;
    end
    check_eq("fin_done",  32'(done_a), 1);
    check_eq("fin_busy",  32'(busy_a), 0);
    check_eq("fin_drive", 32'(drive_a), 0);
    check_eq("fin_pass",  32'(pass_a), (mask == 16'h0) ? 1 : 0);
    check_eq("fin_err",   32'(err_a), model_err(mask, NPat, 255));
    check_eq("fin_ff",    32'(ff_a), model_ff(mask, NPat));
    check_eq("fin_ffv",   32'(ffv_a), model_ffv(mask, NPat));
    check_eq("fin_b_done", 32'(done_b), 1);
    check_eq("fin_b_err",  32'(err_b), 3);
    check_eq("fin_b_ff",   32'(ff_b), 0);
    check_eq("fin_b_pass", 32'(pass_b), 0);
    @(posedge clk); #1;
    check_eq("idle_busy", 32'(busy_a), 0);
    check_eq("idle_done", 32'(done_a), 0);
    check_eq("idle_drive", 32'(drive_a), 0);
    check_eq("idle_pass", 32'(pass_a), (mask == 16'h0) ? 1 : 0);
  endtask

  task automatic reset_mid_sweep();
    int unsigned ndone = 0;
    fault_mask = 16'h00F3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
    end
    check_eq("pre_rst_err", 32'(err_a), model_err(16'h00F3, 9 / Dwell, 255));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_vals("mid_rst");
    for (int k = 0; k < 40; k++) begin
      if (done_a || busy_a) ndone++;
      @(posedge clk); #1;
    end
    check_eq("mid_rst_quiet", ndone, 0);
  endtask

  initial begin
    logic [15:0] m;
    int unsigned pk;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("idle");

    sweep(16'h0000, 1'b0, 0);   // good AND block
    sweep(16'h7FFF, 1'b0, 0);   // result stuck at 1
    sweep(16'h8000, 1'b0, 0);   // result stuck at 0

    for (int i = 0; i < 6; i++) begin
      m  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      pk = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 28) : 0;
      sweep(m, 1'b0, pk);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    reset_mid_sweep();
    sweep(16'h0000, 1'b0, 0);

    // start held high across back-to-back sweeps; the last call releases it.
    sweep(16'h0000, 1'b1, 0);
    sweep(16'($urandom), 1'b1, 0);
    sweep(16'h0000, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
